// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default frame length,
// used by both the SPI slave and the SPI master.
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT = 13;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI wires plus the parallel word handshake of the SPI slave. The slave
// modport is the DUT side; the master modport is the SPI master / consumer side.
interface spi_slave_if import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
);

    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             frame_err;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, rx_ready,
        output miso, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, rx_ready,
        input  miso, rx_data, rx_valid, busy, frame_err
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            q_d    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            sync_q <= {sync_q[STAGES-2:0], d};
            q_d    <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on clk. Optional sticky overrun
// output enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave import spi_pkg::*; #(
    parameter int WIDTH       = SPI_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_if.slave   bus
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic         overrun
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_DONE = SW'(SYNC_STAGES);

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    settle_q;
    logic [WIDTH-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic             rx_valid_q, deliver_q, frame_err_q;
    logic             start, sample, shift, abort;
    logic             sclk_lvl, sclk_rise, sclk_fall;
    logic             cs_lvl, cs_rise, cs_fall;
    logic             mosi_lvl, mosi_rise, mosi_fall;
    logic             unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WAIT_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_d  = state_q;
        start    = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        abort    = 1'b0;
        bus.busy = 1'b0;
        bus.miso = 1'b0;
        unique case (state_q)
            // The synchronizers come out of reset preset to idle, so cs_n is
            // trusted only once the pipeline has refilled with the real pin.
            WAIT_IDLE: if (settle_q == SETTLE_DONE && cs_lvl) state_d = IDLE;
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                bus.busy = 1'b1;
                bus.miso = (cnt_q < CNT_FULL) ? tx_sr_q[WIDTH-1] : 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = (cnt_q != '0) && (cnt_q < CNT_FULL);
                end else begin
                    sample = sclk_rise && (cnt_q < CNT_FULL);
                    shift  = sclk_fall && (cnt_q != '0) && (cnt_q < CNT_FULL);
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q    <= '0;
            cnt_q       <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (state_q == WAIT_IDLE && settle_q != SETTLE_DONE) settle_q <= settle_q + SW'(1);
            frame_err_q <= abort;
            deliver_q   <= sample && (cnt_q == CNT_LAST);
            if (start) begin
                tx_sr_q <= bus.tx_data;
                cnt_q   <= '0;
            end else begin
                if (sample) begin
                    rx_sr_q <= {rx_sr_q[WIDTH-2:0], mosi_lvl};
                    cnt_q   <= cnt_q + CW'(1);
                end
                if (shift) tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
            end
            // A word landing in the same cycle as a read keeps rx_valid high.
            if (deliver_q) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              overrun <= 1'b0;
        else if (deliver_q && rx_valid_q && !bus.rx_ready)    overrun <= 1'b1;
    end
`endif

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI mode-0 master on the interface,
// hand-computed expected words. Overrun checks follow SPI_SLAVE_OVERRUN_EN.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int WIDTH     = SPI_WIDTH_DEFAULT;
    localparam int SCLK_HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic        overrun;
`endif
    int          checks     = 0;
    int          failures   = 0;
    int          ferr_count = 0;
    int          ferr_base  = 0;
    logic [31:0] got;

    spi_slave_if #(.WIDTH(WIDTH)) bus ();

    spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.frame_err === 1'b1) ferr_count <= ferr_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic cs_assert();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (SCLK_HALF) @(negedge clk);
    endtask

    task automatic cs_release();
        repeat (SCLK_HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (4 * SCLK_HALF) @(negedge clk);
    endtask

    // Drives nbits of word MSB first; returns miso as sampled at each rising sclk.
    task automatic clock_bits(input logic [31:0] word, input int nbits, input bit ready_pulse,
                              output logic [31:0] bits);
        bits = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = word[i];
            repeat (SCLK_HALF) @(negedge clk);
            bits = {bits[30:0], bus.miso};
            bus.sclk = 1'b1;
            if (ready_pulse && i == 0) begin
                // rx_ready high only on the clk edge where the new word lands.
                repeat (3) @(negedge clk);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
                repeat (SCLK_HALF - 4) @(negedge clk);
            end else begin
                repeat (SCLK_HALF) @(negedge clk);
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [WIDTH-1:0] tx, input logic [31:0] word, input int nbits,
                         input bit ready_pulse, output logic [31:0] bits);
        bus.tx_data = tx;
        cs_assert();
        clock_bits(word, nbits, ready_pulse, bits);
        cs_release();
    endtask

    task automatic consume();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("consume_valid", 32'(bus.rx_valid), 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.rx_ready = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_miso",      32'(bus.miso),      32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_rx_valid",  32'(bus.rx_valid),  32'h0);
        check("rst_rx_data",   32'(bus.rx_data),   32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("rst_overrun",   32'(overrun),       32'h0);
`endif
        repeat (10) @(negedge clk);

        // Basic exchange: slave returns 0x0ced, master sends 0x1dad.
        ferr_base   = ferr_count;
        bus.tx_data = 13'h0ced;
        cs_assert();
        check("basic_busy_mid", 32'(bus.busy), 32'h1);
        clock_bits(32'h1dad, 13, 1'b0, got);
        cs_release();
        check("basic_miso_word", got,                   32'h0ced);
        check("basic_rx_data",   32'(bus.rx_data),      32'h1dad);
        check("basic_rx_valid",  32'(bus.rx_valid),     32'h1);
        check("basic_busy_idle", 32'(bus.busy),         32'h0);
        check("basic_no_ferr",   32'(ferr_count - ferr_base), 32'h0);

        // New word lands in the same cycle the old one is read.
        frame(13'h0555, 32'h1234, 13, 1'b1, got);
        check("same_cyc_miso",     got,               32'h0555);
        check("same_cyc_rx_data",  32'(bus.rx_data),  32'h1234);
        check("same_cyc_rx_valid", 32'(bus.rx_valid), 32'h1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("same_cyc_overrun",  32'(overrun),      32'h0);
`endif
        consume();
        check("consume_rx_data", 32'(bus.rx_data), 32'h1234);

        // Back-to-back frames with nothing consumed: second word overwrites.
        frame(13'h0f0f, 32'h0001, 13, 1'b0, got);
        check("b2b_first_miso", got,              32'h0f0f);
        check("b2b_first_data", 32'(bus.rx_data), 32'h0001);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("b2b_first_overrun", 32'(overrun),  32'h0);
`endif
        frame(13'h00ff, 32'h1fff, 13, 1'b0, got);
        check("b2b_second_miso",  got,               32'h00ff);
        check("b2b_second_data",  32'(bus.rx_data),  32'h1fff);
        check("b2b_second_valid", 32'(bus.rx_valid), 32'h1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("b2b_overrun",      32'(overrun),      32'h1);
`endif
        consume();

        // cs_n released after 5 bits: one error pulse, nothing delivered.
        ferr_base = ferr_count;
        frame(13'h1abc, 32'h16, 5, 1'b0, got);
        check("abort_ferr_pulses", 32'(ferr_count - ferr_base), 32'h1);
        check("abort_rx_valid",    32'(bus.rx_valid),  32'h0);
        check("abort_rx_data",     32'(bus.rx_data),   32'h1fff);
        ferr_base = ferr_count;
        frame(13'h0333, 32'h0aaa, 13, 1'b0, got);
        check("after_abort_miso",  got,                32'h0333);
        check("after_abort_data",  32'(bus.rx_data),   32'h0aaa);
        check("after_abort_valid", 32'(bus.rx_valid),  32'h1);
        check("after_abort_ferr",  32'(ferr_count - ferr_base), 32'h0);
        consume();

        // 16 sclk cycles: first 13 bits kept, miso low for the extra bits.
        ferr_base = ferr_count;
        frame(13'h1555, 32'h91a5, 16, 1'b0, got);
        check("long_miso",     got,               32'haaa8);
        check("long_rx_data",  32'(bus.rx_data),  32'h1234);
        check("long_rx_valid", 32'(bus.rx_valid), 32'h1);
        check("long_no_ferr",  32'(ferr_count - ferr_base), 32'h0);
        consume();

        // Reset after 7 bits with cs_n held low, then 6 more sclk cycles.
        ferr_base   = ferr_count;
        bus.tx_data = 13'h1f00;
        cs_assert();
        clock_bits(32'h55, 7, 1'b0, got);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clock_bits(32'h3f, 6, 1'b0, got);
        check("rst_mid_miso_seen", got,               32'h0);
        check("rst_mid_busy",      32'(bus.busy),     32'h0);
        check("rst_mid_rx_valid",  32'(bus.rx_valid), 32'h0);
        check("rst_mid_rx_data",   32'(bus.rx_data),  32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("rst_mid_overrun",   32'(overrun),      32'h0);
`endif
        cs_release();
        check("rst_mid_no_ferr",   32'(ferr_count - ferr_base), 32'h0);
        check("rst_mid_still_low", 32'(bus.rx_valid), 32'h0);
        frame(13'h10f0, 32'h0f0f, 13, 1'b0, got);
        check("post_rst_miso",     got,               32'h10f0);
        check("post_rst_rx_data",  32'(bus.rx_data),  32'h0f0f);
        check("post_rst_rx_valid", 32'(bus.rx_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 13, frame length in bits (2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk/cs_n/mosi (2..3).
REQ-003 clk  input  1  system clock; only clock in the block.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select from master, active-low, asynchronous.
REQ-007 mosi  input  1  master-out data, asynchronous.
REQ-008 miso  output  1  slave-out data.
REQ-009 tx_data  input  WIDTH  word returned to master, captured at frame start.
REQ-010 rx_data  output  WIDTH  last complete word received.
REQ-011 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-012 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-013 busy  output  1  frame in progress (state ACTIVE).
REQ-014 frame_err  output  1  one-cycle pulse: cs_n deasserted after 1..WIDTH-1 bits.

Function
REQ-015 SHALL implement SPI mode 0 only, MSB first: sample mosi on sclk rising, change miso on sclk falling.
REQ-016 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops; edges detected on synchronized values; sclk frequency SHALL be at most clk/8.
REQ-017 States: WAIT_IDLE, IDLE, ACTIVE; WAIT_IDLE->IDLE when synced cs_n=1; IDLE->ACTIVE on synced cs_n falling; ACTIVE->IDLE on synced cs_n rising.
REQ-018 On IDLE->ACTIVE: tx shift register loaded with tx_data, bit counter cleared, miso driven with tx_data[WIDTH-1] in the same cycle.
REQ-019 Each synced sclk rising edge in ACTIVE with counter<WIDTH: shift synced mosi into rx shift register LSB, increment counter.
REQ-020 Each synced sclk falling edge in ACTIVE with 0<counter<WIDTH: shift tx register left, miso = next bit.
REQ-021 When counter reaches WIDTH: next clk cycle rx_data = rx shift register, rx_valid=1.
REQ-022 sclk edges after WIDTH bits in the same frame SHALL be ignored; miso=0 afterwards.
REQ-023 miso SHALL be 0 whenever state is not ACTIVE.
REQ-024 rx_valid cleared on clk edge where rx_valid&rx_ready, unless a new word is delivered in the same cycle, in which case rx_valid stays 1 and rx_data takes the new word.
REQ-025 Without consumption, a new completed word SHALL overwrite rx_data (see REQ-030).
REQ-026 cs_n rising with 0<counter<WIDTH: frame_err pulse 1 cycle, partial word discarded, rx_valid/rx_data unchanged; counter=0 or WIDTH: no error.
REQ-027 busy=1 exactly while state is ACTIVE.

Reset
REQ-028 On rst: state WAIT_IDLE, counter 0, shift registers 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, miso 0, overrun 0, synchronizers preset to idle (sclk=0, cs_n=1, mosi=0).
REQ-029 Reset mid-frame SHALL abort the frame; no frame accepted until cs_n observed high (WAIT_IDLE).

Configuration
REQ-030 Macro SPI_SLAVE_OVERRUN_EN: when defined, output overrun (1 bit) is added and set sticky when a word completes while rx_valid=1 and rx_ready=0, cleared only by rst; data still overwritten. When undefined, port absent and overwrite is silent.

Structure
REQ-031 Shared package spi_pkg SHALL hold the state encoding constants and default WIDTH (13), shared with the SPI master.
REQ-032 One sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall edge pulses, instantiated per input.

Verification
REQ-033 WIDTH=13, clk 27 MHz, sclk 10 kHz, tx_data=13'h0ced, master sends 13'h1dad -> rx_data=13'h1dad, rx_valid=1, master receives 13'h0ced.
REQ-034 Two back-to-back frames 13'h0001, 13'h1fff with rx_ready=0 -> rx_data=13'h1fff, overrun=1 (macro on), no overrun port (macro off).
REQ-035 Master deasserts cs_n after 5 bits -> one frame_err pulse, rx_valid stays 0, next full frame 13'h0aaa received correctly.
REQ-036 rst asserted after bit 7 with cs_n held low, then 6 more sclk edges -> no rx_valid, busy=0; next frame after cs_n high is received correctly.
REQ-037 Frame of 16 sclk cycles, WIDTH=13 -> rx_data = first 13 bits, extra bits ignored, miso=0 for bits 14-16, no frame_err.
REQ-038 rx_ready=1 in the same cycle a new word lands -> rx_valid stays 1, rx_data = new word, overrun=0.
